mips_ctrl_pipe: RTL and testbench

Pipelined control path for the MIPS core. It decodes the 6-bit opcode in ID into a control word and carries that word through the ID/EX, EX/MEM and MEM/WB registers. It also detects RAW hazards, inserts bubbles, and optionally drives the EX-stage operand-forwarding selects. It sits between the IF/ID register (which it stalls) and the datapath stage registers (which consume its per-stage control outputs).

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/mips_ctrl_decode.sv | 44 ++++
 rtl/mips_ctrl_pipe.sv | 165 ++++++++++++++++
 tb/tb_mips_ctrl_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode constants, control-word layout and forwarding encodings
package mips_pkg;

    localparam int CTRL_W = 13;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam int CTRL_ALUOP_LSB  = 9;
    localparam int CTRL_ISJUMP     = 8;
    localparam int CTRL_ISNOTCOND  = 7;
    localparam int CTRL_ISEQ       = 6;
    localparam int CTRL_MEMWRITE   = 5;
    localparam int CTRL_MEMREAD    = 4;
    localparam int CTRL_ALUSRC     = 3;
    localparam int CTRL_REGDST     = 2;
    localparam int CTRL_WBI_LSB    = 0;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       is_jump;
        logic       is_not_cond;
        logic       is_eq;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] wbi;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational 6-bit opcode to control-word decoder
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_op,
    output ctrl_t      o_ctrl
);

    logic w_is_jmp;
    logic w_is_store;
    logic w_is_load;
    logic w_reg_dst;

    // Opcodes 2..5 (J, JAL, BEQ, BNE) share the jump/branch path
    assign w_is_jmp   = (i_op == OP_J) || (i_op == OP_JAL) || (i_op == OP_BEQ) || (i_op == OP_BNE);
    assign w_is_store = (i_op[5:3] == 3'd5);
    assign w_is_load  = (i_op[5:3] == 3'd4);
    assign w_reg_dst  = (i_op == OP_RTYPE) || (i_op == OP_BEQ) || (i_op == OP_BNE) ||
                        (i_op == OP_SB) || (i_op == OP_SH) || (i_op == OP_SW);

    // Build the control word field by field
    always_comb begin
        o_ctrl = '0;
        if (i_op[5]) begin
            o_ctrl.alu_op = 4'b0000;
        end else if (w_is_jmp) begin
            o_ctrl.alu_op = 4'b0001;
        end else if (i_op == OP_RTYPE) begin
            o_ctrl.alu_op = 4'b0010;
        end else begin
            o_ctrl.alu_op = i_op[3:0];
        end
        o_ctrl.is_jump     = w_is_jmp;
        o_ctrl.is_not_cond = ~i_op[2];
        o_ctrl.is_eq       = ~i_op[0];
        o_ctrl.mem_write   = w_is_store;
        o_ctrl.mem_read    = w_is_load;
        o_ctrl.alu_src     = i_op[5] | i_op[3];
        o_ctrl.reg_dst     = w_reg_dst;
        o_ctrl.wbi[0]      = ~i_op[5];
        o_ctrl.wbi[1]      = ~(w_is_store | w_is_jmp);
    end

endmodule

// File: rtl/mips_ctrl_pipe.sv
// rtl/mips_ctrl_pipe.sv - MIPS control pipeline with RAW stall and optional forwarding (MIPS_CTRL_FWD_EN)
module mips_ctrl_pipe
    import mips_pkg::*;
#(
    parameter int AW  = 5,
    parameter int OPW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [OPW-1:0]    id_opcode,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic [AW-1:0]     id_rd,
    input  logic              ex_flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [AW-1:0]     ex_rs,
    output logic [AW-1:0]     ex_rt,
    output logic [AW-1:0]     ex_dst,
    output logic              mem_valid,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    output logic [1:0]        mem_wbi,
    output logic [AW-1:0]     mem_dst,
    output logic              wb_valid,
    output logic [1:0]        wb_wbi,
    output logic [AW-1:0]     wb_dst,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    ctrl_t         w_dec;
    logic [AW-1:0] w_id_dst;
    logic          w_ex_hit;
    logic          w_hazard;
    logic          w_stall;

    logic          r_ex_valid;
    ctrl_t         r_ex_ctrl;
    logic [AW-1:0] r_ex_rs;
    logic [AW-1:0] r_ex_rt;
    logic [AW-1:0] r_ex_dst;

    logic          r_mem_valid;
    logic          r_mem_mw;
    logic          r_mem_mr;
    logic [1:0]    r_mem_wbi;
    logic [AW-1:0] r_mem_dst;

    logic          r_wb_valid;
    logic [1:0]    r_wb_wbi;
    logic [AW-1:0] r_wb_dst;

    // A stage writes register r when it carries a live register write to r; r0 is never a target
    function automatic logic f_writes(input logic v, input logic rw,
                                      input logic [AW-1:0] dst, input logic [AW-1:0] r);
        return v & rw & (dst == r) & (r != '0);
    endfunction

    mips_ctrl_decode u_decode (
        .i_op   (id_opcode[5:0]),
        .o_ctrl (w_dec)
    );

    assign w_id_dst = w_dec.reg_dst ? id_rd : id_rt;
    assign w_ex_hit = f_writes(r_ex_valid, r_ex_ctrl.wbi[1], r_ex_dst, id_rs) |
                      f_writes(r_ex_valid, r_ex_ctrl.wbi[1], r_ex_dst, id_rt);

`ifdef MIPS_CTRL_FWD_EN
    // Only a load in EX cannot be bypassed in time
    assign w_hazard = w_ex_hit & r_ex_ctrl.mem_read;

    // Operand bypass select; the younger producer in MEM wins over WB
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (f_writes(r_mem_valid, r_mem_wbi[1], r_mem_dst, r_ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (f_writes(r_wb_valid, r_wb_wbi[1], r_wb_dst, r_ex_rs)) begin
            fwd_a = FWD_WB;
        end
        if (f_writes(r_mem_valid, r_mem_wbi[1], r_mem_dst, r_ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (f_writes(r_wb_valid, r_wb_wbi[1], r_wb_dst, r_ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end
`else
    logic w_mem_hit;

    // Without bypass, any producer still in EX or MEM blocks the reader
    assign w_mem_hit = f_writes(r_mem_valid, r_mem_wbi[1], r_mem_dst, id_rs) |
                       f_writes(r_mem_valid, r_mem_wbi[1], r_mem_dst, id_rt);
    assign w_hazard  = w_ex_hit | w_mem_hit;
    assign fwd_a     = FWD_RF;
    assign fwd_b     = FWD_RF;
`endif

    // A flush kills the ID instruction, so a stall is meaningless that cycle
    assign w_stall  = id_valid & ~ex_flush & w_hazard;
    assign id_stall = w_stall;

    // ID/EX register: bubble on flush or stall, otherwise capture the decoded instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_dst   <= '0;
        end else if (ex_flush || w_stall) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_dst   <= '0;
        end else begin
            r_ex_valid <= id_valid;
            r_ex_ctrl  <= w_dec;
            r_ex_rs    <= id_rs;
            r_ex_rt    <= id_rt;
            r_ex_dst   <= w_id_dst;
        end
    end

    // EX/MEM and MEM/WB registers advance every cycle; memory never back-pressures
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid <= 1'b0;
            r_mem_mw    <= 1'b0;
            r_mem_mr    <= 1'b0;
            r_mem_wbi   <= '0;
            r_mem_dst   <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_wbi    <= '0;
            r_wb_dst    <= '0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_mw    <= r_ex_ctrl.mem_write;
            r_mem_mr    <= r_ex_ctrl.mem_read;
            r_mem_wbi   <= r_ex_ctrl.wbi;
            r_mem_dst   <= r_ex_dst;
            r_wb_valid  <= r_mem_valid;
            r_wb_wbi    <= r_mem_wbi;
            r_wb_dst    <= r_mem_dst;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_ctrl      = r_ex_ctrl;
    assign ex_rs        = r_ex_rs;
    assign ex_rt        = r_ex_rt;
    assign ex_dst       = r_ex_dst;
    assign mem_valid    = r_mem_valid;
    assign mem_memWrite = r_mem_mw;
    assign mem_memRead  = r_mem_mr;
    assign mem_wbi      = r_mem_wbi;
    assign mem_dst      = r_mem_dst;
    assign wb_valid     = r_wb_valid;
    assign wb_wbi       = r_wb_wbi;
    assign wb_dst       = r_wb_dst;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// tb/tb_mips_ctrl_pipe.sv - self-checking bench for mips_ctrl_pipe against a stage-level reference model
module tb_mips_ctrl_pipe;

`ifdef MIPS_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_flush;
    logic        id_stall;
    logic        ex_valid;
    logic [12:0] ex_ctrl;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic        mem_valid, mem_memWrite, mem_memRead;
    logic [1:0]  mem_wbi;
    logic [4:0]  mem_dst;
    logic        wb_valid;
    logic [1:0]  wb_wbi;
    logic [4:0]  wb_dst;
    logic [1:0]  fwd_a, fwd_b;

    int n_checks = 0;
    int n_errors = 0;

    mips_ctrl_pipe #(.AW(5), .OPW(6)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_flush(ex_flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .mem_valid(mem_valid), .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_wbi(mem_wbi), .mem_dst(mem_dst),
        .wb_valid(wb_valid), .wb_wbi(wb_wbi), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        v;
        bit [12:0] c;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit [4:0]  dst;
    } stg_t;

    stg_t m_ex, m_mem, m_wb;

    function automatic bit [12:0] ref_decode(input bit [5:0] op);
        int      o;
        bit      jmp;
        bit      rdst;
        bit      rw;
        bit [3:0] alu;
        o    = int'(op);
        jmp  = (o >= 2 && o <= 5);
        rdst = (o == 0 || o == 4 || o == 5 || o == 40 || o == 41 || o == 43);
        rw   = !((op[5:3] == 3'd5) || jmp);
        if (op[5])       alu = 4'd0;
        else if (jmp)    alu = 4'd1;
        else if (o == 0) alu = 4'd2;
        else             alu = op[3:0];
        return {alu, jmp, ~op[2], ~op[0], op[5:3] == 3'd5, op[5:3] == 3'd4,
                op[5] | op[3], rdst, rw, ~op[5]};
    endfunction

    function automatic bit writes(input stg_t s, input bit [4:0] r);
        return s.v && s.c[1] && (s.dst == r) && (r != 0);
    endfunction

    function automatic bit exp_stall();
        bit ex_hit, mem_hit;
        ex_hit  = writes(m_ex, id_rs) || writes(m_ex, id_rt);
        mem_hit = writes(m_mem, id_rs) || writes(m_mem, id_rt);
        if (!id_valid || ex_flush) return 1'b0;
        if (FWD) return ex_hit && m_ex.c[4];
        return ex_hit || mem_hit;
    endfunction

    function automatic bit [1:0] exp_fwd(input bit [4:0] r);
        if (!FWD) return 2'b00;
        if (writes(m_mem, r)) return 2'b01;
        if (writes(m_wb, r))  return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_ex  = '{default: 0};
        m_mem = '{default: 0};
        m_wb  = '{default: 0};
    endtask

    task automatic model_next();
        bit        st;
        bit [12:0] c;
        st    = exp_stall();
        c     = ref_decode(id_opcode);
        m_wb  = m_mem;
        m_mem = m_ex;
        if (ex_flush || st) m_ex = '{default: 0};
        else m_ex = '{id_valid, c, id_rs, id_rt, c[2] ? id_rd : id_rt};
    endtask

    task automatic compare_model();
        chk("id_stall",     id_stall,     exp_stall());
        chk("fwd_a",        fwd_a,        exp_fwd(m_ex.rs));
        chk("fwd_b",        fwd_b,        exp_fwd(m_ex.rt));
        chk("ex_valid",     ex_valid,     m_ex.v);
        chk("ex_ctrl",      ex_ctrl,      m_ex.c);
        chk("ex_rs",        ex_rs,        m_ex.rs);
        chk("ex_rt",        ex_rt,        m_ex.rt);
        chk("ex_dst",       ex_dst,       m_ex.dst);
        chk("mem_valid",    mem_valid,    m_mem.v);
        chk("mem_memWrite", mem_memWrite, m_mem.c[5]);
        chk("mem_memRead",  mem_memRead,  m_mem.c[4]);
        chk("mem_wbi",      mem_wbi,      m_mem.c[1:0]);
        chk("mem_dst",      mem_dst,      m_mem.dst);
        chk("wb_valid",     wb_valid,     m_wb.v);
        chk("wb_wbi",       wb_wbi,       m_wb.c[1:0]);
        chk("wb_dst",       wb_dst,       m_wb.dst);
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) if (rst_n) model_next();

    always @(negedge clk) begin
        #1;
        if (rst_n) compare_model();
    end

    task automatic drive(input bit v, input bit [5:0] op, input bit [4:0] rs,
                         input bit [4:0] rt, input bit [4:0] rd, input bit fl);
        @(negedge clk);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        ex_flush  = fl;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (4) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    localparam bit [5:0] OPS [10] = '{6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3, 6'd8, 6'd13};

    initial begin
        int       n;
        bit       held;
        bit [5:0] r_op;
        bit [4:0] r_rs, r_rt, r_rd;

        rst_n = 1'b0;
        id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0; id_rd = 0; ex_flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst ex_valid",  ex_valid,  0);
        chk("rst mem_valid", mem_valid, 0);
        chk("rst wb_valid",  wb_valid,  0);
        chk("rst ex_ctrl",   ex_ctrl,   0);
        chk("rst id_stall",  id_stall,  0);
        chk("rst fwd_a",     fwd_a,     0);
        chk("rst fwd_b",     fwd_b,     0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type latency through the three stage registers
        drive(1, 0, 1, 2, 5, 0);
        after_edge();
        chk("rtype ex_ctrl",  ex_ctrl,  13'h04C7);
        chk("rtype ex_valid", ex_valid, 1);
        chk("rtype ex_dst",   ex_dst,   5);
        drive(0, 0, 0, 0, 0, 0);
        after_edge();
        chk("rtype mem_valid", mem_valid, 1);
        chk("rtype mem_wbi",   mem_wbi,   2'b11);
        chk("rtype wb_early",  wb_valid,  0);
        drive(0, 0, 0, 0, 0, 0);
        after_edge();
        chk("rtype wb_valid", wb_valid, 1);
        chk("rtype wb_dst",   wb_dst,   5);

        // Load-use on r8
        drain();
        drive(1, 35, 0, 8, 0, 0);
        after_edge();
        chk("lw ex_ctrl", ex_ctrl, 13'h009A);
        chk("lw ex_dst",  ex_dst,  8);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 8, 1, 9, 0);
            #2;
            if (!id_stall) break;
            n++;
        end
        chk("loaduse stall cycles", n, FWD ? 1 : 2);
        after_edge();
        chk("loaduse ex_valid", ex_valid, 1);
        chk("loaduse fwd_a",    fwd_a,    FWD ? 2'b10 : 2'b00);

        // ALU producer followed by back-to-back readers of r3
        drain();
        drive(1, 0, 1, 2, 3, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 3, 3, 4, 0);
            #2;
            if (!id_stall) break;
            n++;
        end
        chk("alu stall cycles", n, FWD ? 0 : 2);
        after_edge();
        chk("alu fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
        chk("alu fwd_b", fwd_b, FWD ? 2'b01 : 2'b00);
        drive(1, 0, 3, 0, 6, 0);
        after_edge();
        chk("alu2 fwd_a", fwd_a, FWD ? 2'b10 : 2'b00);

        // Register 0 never hazards or forwards
        drain();
        drive(1, 0, 1, 2, 0, 0);
        drive(1, 0, 0, 0, 7, 0);
        #2;
        chk("r0 stall", id_stall, 0);
        after_edge();
        chk("r0 fwd_a", fwd_a, 0);
        chk("r0 fwd_b", fwd_b, 0);

        // Flush wins over a pending load-use stall
        drain();
        drive(1, 35, 0, 8, 0, 0);
        drive(1, 0, 8, 1, 9, 1);
        #2;
        chk("flush stall", id_stall, 0);
        after_edge();
        chk("flush ex_valid", ex_valid, 0);

        // Branch and store never cause a stall downstream
        drain();
        drive(1, 4, 1, 2, 3, 0);
        after_edge();
        chk("beq ex_ctrl", ex_ctrl, 13'h0345);
        drive(1, 43, 1, 2, 3, 0);
        #2;
        chk("beq no stall", id_stall, 0);
        after_edge();
        chk("sw ex_ctrl", ex_ctrl, 13'h00AC);
        drive(1, 0, 3, 3, 5, 0);
        #2;
        chk("sw no stall", id_stall, 0);

        // Reset asserted while a load-use stall is pending
        drain();
        drive(1, 35, 0, 8, 0, 0);
        drive(1, 0, 8, 1, 9, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst ex_valid", ex_valid, 0);
        chk("midrst id_stall", id_stall, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        after_edge();
        chk("postrst ex_valid",  ex_valid,  0);
        chk("postrst mem_valid", mem_valid, 0);
        chk("postrst wb_valid",  wb_valid,  0);

        // Random traffic; a stalled instruction stays in ID until it is accepted
        held = 0;
        r_op = 0; r_rs = 0; r_rt = 0; r_rd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!held) begin
                r_op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 9)];
                r_rs = 5'($urandom_range(0, 3));
                r_rt = 5'($urandom_range(0, 3));
                r_rd = 5'($urandom_range(0, 3));
            end
            drive($urandom_range(0, 5) != 0 || held, r_op, r_rs, r_rt, r_rd,
                  $urandom_range(0, 7) == 0);
            #2;
            held = exp_stall();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
